wb_regfile: RTL and testbench

Writeback stage and architectural register file for the RV32I five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it into the 32×32 integer register file. Serves the decode stage's two read ports with same-cycle write-to-read bypass. Keeps a count of committed register writes for debug and performance monitoring.

---
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 RV32I integer register file.
// Ports: clk/rst (sync, active-high); MEM/WB inputs W_wb, W_wen_rf,
//   W_ALUresult, W_DMEMresult, W_PC_next, W_rd; decode read addresses
//   D_rs1/D_rs2 -> D_rdata1/D_rdata2 (comb, bypassed); W_wdata (comb
//   writeback value); W_commit (comb); wb_count (registered commit count).
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  W_wb,
    input  logic        W_wen_rf,
    input  logic [31:0] W_ALUresult,
    input  logic [31:0] W_DMEMresult,
    input  logic [31:0] W_PC_next,
    input  logic [4:0]  W_rd,
    input  logic [4:0]  D_rs1,
    input  logic [4:0]  D_rs2,
    output logic [31:0] D_rdata1,
    output logic [31:0] D_rdata2,
    output logic [31:0] W_wdata,
    output logic        W_commit,
    output logic [31:0] wb_count
);

    // x0 is hardwired, so only x1..x31 are stored
    logic [31:0] regs [31:1];

    always_comb begin
        W_wdata = 32'h0;
        case (W_wb)
            2'b00:   W_wdata = W_ALUresult;
            2'b01:   W_wdata = W_DMEMresult;
            2'b10:   W_wdata = W_PC_next;
            default: W_wdata = 32'h0;
        endcase
    end

    // Source select 11 is reserved and never writes
    assign W_commit = W_wen_rf & (W_rd != 5'd0) & (W_wb != 2'b11) & ~rst;

    // Same-cycle bypass makes a committing write visible to decode
    always_comb begin
        D_rdata1 = 32'h0;
        if (!rst && D_rs1 != 5'd0) begin
            if (W_commit && D_rs1 == W_rd)
                D_rdata1 = W_wdata;
            else
                D_rdata1 = regs[D_rs1];
        end
    end

    always_comb begin
        D_rdata2 = 32'h0;
        if (!rst && D_rs2 != 5'd0) begin
            if (W_commit && D_rs2 == W_rd)
                D_rdata2 = W_wdata;
            else
                D_rdata2 = regs[D_rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= (i == 2) ? SP_INIT : 32'h0;
            wb_count <= 32'h0;
        end else if (W_commit) begin
            regs[W_rd] <= W_wdata;
            wb_count   <= wb_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// Reference model + scoreboard queue of expected outputs per cycle.
module tb_wb_regfile;

    localparam logic [31:0] SP = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  W_wb;
    logic        W_wen_rf;
    logic [31:0] W_ALUresult, W_DMEMresult, W_PC_next;
    logic [4:0]  W_rd, D_rs1, D_rs2;
    logic [31:0] D_rdata1, D_rdata2, W_wdata, wb_count;
    logic        W_commit;

    wb_regfile #(.SP_INIT(SP)) dut (
        .clk(clk), .rst(rst), .W_wb(W_wb), .W_wen_rf(W_wen_rf),
        .W_ALUresult(W_ALUresult), .W_DMEMresult(W_DMEMresult),
        .W_PC_next(W_PC_next), .W_rd(W_rd), .D_rs1(D_rs1), .D_rs2(D_rs2),
        .D_rdata1(D_rdata1), .D_rdata2(D_rdata2), .W_wdata(W_wdata),
        .W_commit(W_commit), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rd1, rd2, wd, cnt;
        logic        cm;
        bit          cnt_ok;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m[32];
    logic [31:0] cnt_m;
    bit          cnt_known;
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mux(input logic [1:0] wb,
            input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        case (wb)
            2'b00:   return a;
            2'b01:   return d;
            2'b10:   return p;
            default: return 32'h0;
        endcase
    endfunction

    // One pipeline slot: drive, push expectation, compare at negedge,
    // then advance the model across the rising edge.
    task automatic step(input string tag, input bit r, input logic [1:0] wb,
            input bit wen, input logic [31:0] a, input logic [31:0] d,
            input logic [31:0] p, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e, g;
        logic [31:0] wd;
        logic cm;
        rst = r; W_wb = wb; W_wen_rf = wen; W_ALUresult = a;
        W_DMEMresult = d; W_PC_next = p; W_rd = rd; D_rs1 = rs1; D_rs2 = rs2;
        wd = mux(wb, a, d, p);
        cm = wen && rd != 0 && wb != 2'b11 && !r;
        e.tag = tag; e.wd = wd; e.cm = cm;
        e.cnt = cnt_m; e.cnt_ok = cnt_known;
        e.rd1 = (r || rs1 == 0) ? 32'h0 : (cm && rs1 == rd) ? wd : m[rs1];
        e.rd2 = (r || rs2 == 0) ? 32'h0 : (cm && rs2 == rd) ? wd : m[rs2];
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk({g.tag, ".rd1"}, D_rdata1, g.rd1);
        chk({g.tag, ".rd2"}, D_rdata2, g.rd2);
        chk({g.tag, ".wdata"}, W_wdata, g.wd);
        chk({g.tag, ".commit"}, {31'h0, W_commit}, {31'h0, g.cm});
        if (g.cnt_ok) chk({g.tag, ".count"}, wb_count, g.cnt);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
            m[2] = SP;
            cnt_m = 32'h0;
            cnt_known = 1'b1;
        end else if (cm) begin
            m[rd] = wd;
            cnt_m = cnt_m + 32'd1;
        end
        #1;
    endtask

    task automatic idle(input string tag, input logic [4:0] rs1,
                        input logic [4:0] rs2);
        step(tag, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cnt_m = 32'h0; cnt_known = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        rst = 1; W_wb = 0; W_wen_rf = 0; W_ALUresult = 0; W_DMEMresult = 0;
        W_PC_next = 0; W_rd = 0; D_rs1 = 0; D_rs2 = 0;
        #1;

        // Reset held two cycles, with a write presented that must be dropped
        step("rst0", 1, 2'b00, 1, 32'h5555_5555, 0, 0, 5'd3, 5'd3, 5'd2);
        step("rst1", 1, 2'b00, 0, 0, 0, 0, 5'd0, 5'd2, 5'd3);
        for (int i = 0; i < 32; i++)
            idle("rstrd", 5'(i), 5'(31 - i));
        chk("sp_value", m[2], SP);

        // ALU write with bypass, then array read
        step("alu_byp", 0, 2'b00, 1, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd5, 5'd5);
        idle("alu_arr", 5'd5, 5'd2);
        chk("alu_cnt", wb_count, 32'd1);

        // Source selects
        step("dmem", 0, 2'b01, 1, 32'h1, 32'hFFFF_FF80, 32'h2, 5'd6, 5'd6, 5'd1);
        step("pcn", 0, 2'b10, 1, 32'h1, 32'h2, 32'h0000_0104, 5'd1, 5'd6, 5'd1);
        step("rsvd", 0, 2'b11, 1, 32'h7, 32'h7, 32'h7, 5'd6, 5'd6, 5'd1);
        idle("src_arr", 5'd6, 5'd1);
        chk("x6_val", D_rdata1, 32'hFFFF_FF80);
        chk("x1_val", D_rdata2, 32'h0000_0104);

        // x0 protection
        step("x0_wr", 0, 2'b00, 1, 32'h1234_5678, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("x0_rd", 5'd0, 5'd0);

        // Reset asserted in the cycle of a write to x7
        step("mid_rst", 1, 2'b00, 1, 32'hAAAA_AAAA, 0, 0, 5'd7, 5'd7, 5'd7);
        idle("mid_after", 5'd7, 5'd5);
        step("first_cm", 0, 2'b00, 1, 32'h0000_0042, 0, 0, 5'd9, 5'd9, 5'd7);
        idle("first_cnt", 5'd9, 5'd2);

        // Counter wrap via preloaded count
        @(negedge clk);
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        cnt_m = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        step("wrap", 0, 2'b00, 1, 32'h0BAD_F00D, 0, 0, 5'd4, 5'd4, 5'd4);
        idle("wrap_after", 5'd4, 5'd0);
        chk("wrap_zero", wb_count, 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 300; k++)
            step("rand", ($urandom_range(0, 24) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
